voice_sequencer: RTL

//  Step sequencer that drives one voice's tone_freq and gate from a small writable pattern memory.
//  It replaces a free-running slow-clock gate with musical note/rest/tie sequencing.

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_step_timer.sv | 47 ++++
 rtl/voice_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the voice step sequencer.
// Pattern entry layout: {rest[17], tie[16], freq[15:0]}.
package seq_pkg;

    localparam int unsigned ENTRY_W  = 18;
    localparam int unsigned FREQ_LSB = 0;
    localparam int unsigned FREQ_MSB = 15;
    localparam int unsigned TIE_BIT  = 16;
    localparam int unsigned REST_BIT = 17;

    typedef enum logic {
        S_IDLE,
        S_PLAY
    } state_e;

endpackage

// File: rtl/seq_step_timer.sv
// Step timer for voice_sequencer: counts clk cycles within a step.
// Ports:
//   clk_i        voice clock
//   rst_i        synchronous reset, active-high
//   clear_i      force the count back to 0 (held while not playing)
//   en_i         count enable
//   gate_off_o   strobe while count == GATE_DIV-1
//   step_end_o   strobe while count == TICK_DIV-1 (count wraps to 0 next cycle)
module seq_step_timer #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned GATE_DIV = 75000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic gate_off_o,
    output logic step_end_o
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] GATE_LAST = CW'(GATE_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == TICK_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign gate_off_o = en_i && (cnt_q == GATE_LAST);
    assign step_end_o = en_i && (cnt_q == TICK_LAST);

endmodule

// File: rtl/voice_sequencer.sv
// Step sequencer driving one voice's tone_freq and gate from a writable pattern memory.
// Optional feature: define SEQ_TIE_EN to honour the per-entry tie bit (gate held
// through the gate-off point into the next step). Without it the tie bit is stored only.
// Ports:
//   clk_i, rst_i         voice clock, synchronous active-high reset
//   run_i                level: 1 = play, 0 = stop
//   last_step_i          index of the final step before wrapping to 0
//   wr_en_i/addr/data    pattern write port {rest, tie, freq}
//   tone_freq_o, gate_o  to the voice
//   step_o               step now playing
//   step_pulse_o         1-cycle strobe on each step advance
//   busy_o               1 while playing
module voice_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned STEPS    = 16,
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned GATE_DIV = 75000,
    localparam int unsigned AW      = $clog2(STEPS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               run_i,
    input  logic [AW-1:0]      last_step_i,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [ENTRY_W-1:0] wr_data_i,
    output logic [15:0]        tone_freq_o,
    output logic               gate_o,
    output logic [AW-1:0]      step_o,
    output logic               step_pulse_o,
    output logic               busy_o
);

    logic [ENTRY_W-1:0] mem_q [STEPS];

    state_e        state_q, state_d;
    logic [15:0]   tone_q, tone_d;
    logic          gate_q, gate_d;
    logic [AW-1:0] step_q, step_d;
    logic          pulse_q, pulse_d;
    logic          tie_q, tie_d;

    logic          gate_off, step_end, tie_hold;
    logic [AW-1:0] nxt_step;
    logic [ENTRY_W-1:0] rd_entry;

    // Writes land at the clock edge, so a same-cycle read sees the old entry.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    seq_step_timer #(
        .TICK_DIV (TICK_DIV),
        .GATE_DIV (GATE_DIV)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    ((state_q != S_PLAY) || !run_i),
        .en_i       (state_q == S_PLAY),
        .gate_off_o (gate_off),
        .step_end_o (step_end)
    );

    // >= so that lowering last_step below the playing step wraps at this step's end.
    assign nxt_step = (step_q >= last_step_i) ? '0 : step_q + 1'b1;
    assign rd_entry = (state_q == S_IDLE) ? mem_q[0] : mem_q[nxt_step];

`ifdef SEQ_TIE_EN
    assign tie_hold = tie_q;
`else
    logic unused_tie;
    assign tie_hold   = 1'b0;
    assign unused_tie = tie_q;
`endif

    always_comb begin
        state_d = state_q;
        tone_d  = tone_q;
        gate_d  = gate_q;
        step_d  = step_q;
        pulse_d = 1'b0;
        tie_d   = tie_q;
        unique case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_PLAY;
                    step_d  = '0;
                    tone_d  = rd_entry[FREQ_MSB:FREQ_LSB];
                    gate_d  = ~rd_entry[REST_BIT];
                    tie_d   = rd_entry[TIE_BIT];
                end
            end
            S_PLAY: begin
                if (!run_i) begin
                    // tone_freq is kept so the voice release keeps its pitch.
                    state_d = S_IDLE;
                    gate_d  = 1'b0;
                    step_d  = '0;
                end else if (step_end) begin
                    step_d  = nxt_step;
                    pulse_d = 1'b1;
                    tone_d  = rd_entry[FREQ_MSB:FREQ_LSB];
                    gate_d  = ~rd_entry[REST_BIT];
                    tie_d   = rd_entry[TIE_BIT];
                end else if (gate_off && !tie_hold) begin
                    gate_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            tone_q  <= '0;
            gate_q  <= 1'b0;
            step_q  <= '0;
            pulse_q <= 1'b0;
            tie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tone_q  <= tone_d;
            gate_q  <= gate_d;
            step_q  <= step_d;
            pulse_q <= pulse_d;
            tie_q   <= tie_d;
        end
    end

    assign tone_freq_o  = tone_q;
    assign gate_o       = gate_q;
    assign step_o       = step_q;
    assign step_pulse_o = pulse_q;
    assign busy_o       = (state_q == S_PLAY);

endmodule
